// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter merging ALU (A) and memory-load (B) results into one
// register-file write port. Each side has a one-entry buffer feeding a registered write stage.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [31:0]      busy_mask
);

    logic             a_full, b_full;
    logic [4:0]       a_addr_q, b_addr_q;
    logic [WIDTH-1:0] a_data_q, b_data_q;
    logic             a_young, b_young;
    logic             prio_b;

    logic             grant_a, grant_b;
    logic             a_load, b_load;
    logic             a_stays, b_stays;
    logic             contended;
    logic [4:0]       sel_addr;
    logic [WIDTH-1:0] sel_data;

    // Same-address collisions are ordered by age so the later write lands last;
    // only different-address collisions move the round-robin pointer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full && b_full) begin
            if (a_addr_q == b_addr_q) begin
                if (a_young && !b_young) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end else if (prio_b) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else if (a_full) begin
            grant_a = 1'b1;
        end else if (b_full) begin
            grant_b = 1'b1;
        end
    end

    assign contended = a_full && b_full && (a_addr_q != b_addr_q);
    assign a_ready   = !a_full || grant_a;
    assign b_ready   = !b_full || grant_b;
    assign a_load    = a_valid && a_ready;
    assign b_load    = b_valid && b_ready;
    assign a_stays   = a_full && !grant_a;
    assign b_stays   = b_full && !grant_b;
    assign sel_addr  = grant_b ? b_addr_q : a_addr_q;
    assign sel_data  = grant_b ? b_data_q : a_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_full   <= 1'b0;
            b_full   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
            a_young  <= 1'b0;
            b_young  <= 1'b0;
            prio_b   <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // An entry loaded next to a waiting entry is younger than it.
            if (a_load) begin
                a_full   <= 1'b1;
                a_addr_q <= a_addr;
                a_data_q <= a_data;
                a_young  <= b_stays;
            end else if (grant_a) begin
                a_full  <= 1'b0;
                a_young <= 1'b0;
            end else if (b_load && a_stays) begin
                a_young <= 1'b0;
            end

            if (b_load) begin
                b_full   <= 1'b1;
                b_addr_q <= b_addr;
                b_data_q <= b_data;
                b_young  <= a_stays;
            end else if (grant_b) begin
                b_full  <= 1'b0;
                b_young <= 1'b0;
            end else if (a_load && b_stays) begin
                b_young <= 1'b0;
            end

            if (contended) begin
                prio_b <= grant_a;
            end

            // Writes to r0 are consumed but never reach the register file.
            if (grant_a || grant_b) begin
                rf_we    <= (sel_addr != 5'd0);
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        if (a_full) begin
            busy_mask = busy_mask | (32'd1 << a_addr_q);
        end
        if (b_full) begin
            busy_mask = busy_mask | (32'd1 << b_addr_q);
        end
        if (rf_we) begin
            busy_mask = busy_mask | (32'd1 << rf_waddr);
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    int check_count;
    int error_count;

    regfile_wb_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input string tag, input logic [4:0] addr, input logic [31:0] data);
        checkOutput({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        checkOutput({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, addr});
        checkOutput({tag, "_data"}, rf_wdata, data);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        checkOutput("rst_we", {31'd0, rf_we}, 32'd0);
        checkOutput("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        checkOutput("rst_wdata", rf_wdata, 32'd0);
        checkOutput("rst_busy", busy_mask, 32'd0);
        rst_n = 1'b1;
        tick();

        // A alone
        applyStimulus(1'b1, 5'd5, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
        checkOutput("solo_aready", {31'd0, a_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("solo_we_e1", {31'd0, rf_we}, 32'd0);
        checkOutput("solo_busy_e1", busy_mask, 32'h0000_0020);
        tick();
        expectWrite("solo_e2", 5'd5, 32'h1111_1111);
        checkOutput("solo_busy_e2", busy_mask, 32'h0000_0020);
        tick();
        checkOutput("solo_we_e3", {31'd0, rf_we}, 32'd0);
        checkOutput("solo_busy_e3", busy_mask, 32'd0);
        checkOutput("solo_hold_addr", {27'd0, rf_waddr}, 32'd5);

        // First collision after reset favours A, the next one favours B
        applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("rr1_busy", busy_mask, 32'h0000_0018);
        checkOutput("rr1_aready", {31'd0, a_ready}, 32'd1);
        checkOutput("rr1_bready", {31'd0, b_ready}, 32'd0);
        tick();
        expectWrite("rr1_first", 5'd3, 32'hA);
        tick();
        expectWrite("rr1_second", 5'd4, 32'hB);
        tick();
        checkOutput("rr1_idle", {31'd0, rf_we}, 32'd0);
        applyStimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h200);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("rr2_bready", {31'd0, b_ready}, 32'd1);
        checkOutput("rr2_aready", {31'd0, a_ready}, 32'd0);
        tick();
        expectWrite("rr2_first", 5'd11, 32'h200);
        tick();
        expectWrite("rr2_second", 5'd10, 32'h100);
        tick();

        // Younger A to r13 must wait behind the older B to r13
        applyStimulus(1'b1, 5'd12, 32'h1, 1'b1, 5'd13, 32'h2);
        tick();
        applyStimulus(1'b1, 5'd13, 32'h3, 1'b0, 5'd0, 32'd0);
        checkOutput("age_aready", {31'd0, a_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expectWrite("age_e2", 5'd12, 32'h1);
        checkOutput("age_busy", busy_mask, 32'h0000_3000);
        tick();
        expectWrite("age_e3", 5'd13, 32'h2);
        tick();
        expectWrite("age_e4", 5'd13, 32'h3);
        tick();
        checkOutput("age_idle", {31'd0, rf_we}, 32'd0);

        // Equal-age same-address collision: A first, so B's value lands last
        applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("same_busy", busy_mask, 32'h0000_0080);
        tick();
        expectWrite("same_first", 5'd7, 32'h1);
        tick();
        expectWrite("same_last", 5'd7, 32'h2);
        tick();

        // Writes to r0 are swallowed
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checkOutput("zero_bready", {31'd0, b_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("zero_busy_e1", busy_mask, 32'd0);
        checkOutput("zero_we_e1", {31'd0, rf_we}, 32'd0);
        tick();
        checkOutput("zero_we_e2", {31'd0, rf_we}, 32'd0);
        checkOutput("zero_busy_e2", busy_mask, 32'd0);
        tick();
        checkOutput("zero_we_e3", {31'd0, rf_we}, 32'd0);

        // Back-to-back stream from A
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0);
            checkOutput($sformatf("b2b_aready_%0d", i), {31'd0, a_ready}, 32'd1);
            tick();
            if (i >= 2) begin
                expectWrite($sformatf("b2b_%0d", i - 1), 5'(i - 1), 32'((i - 1) * 16));
            end
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        expectWrite("b2b_8", 5'd8, 32'h80);
        tick();
        checkOutput("b2b_idle", {31'd0, rf_we}, 32'd0);

        // Reset while both buffers hold writes
        applyStimulus(1'b1, 5'd20, 32'h77, 1'b1, 5'd21, 32'h88);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("mid_busy_pre", busy_mask, 32'h0030_0000);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_we", {31'd0, rf_we}, 32'd0);
        checkOutput("mid_busy", busy_mask, 32'd0);
        checkOutput("mid_waddr", {27'd0, rf_waddr}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("mid_after_we_%0d", i), {31'd0, rf_we}, 32'd0);
            checkOutput($sformatf("mid_after_busy_%0d", i), busy_mask, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
